// File: rtl/ifetch_buffer_if.sv
// ifetch_buffer_if: handshake bundle between the instruction prefetch unit,
// the instruction memory and decode.
//   imem_req_*  : fetch request channel (prefetcher -> imem)
//   imem_resp_* : in-order response channel (imem -> prefetcher)
//   out_*       : buffered instruction stream (prefetcher -> decode)
// Modports:
//   master : the prefetch unit (ifetch_buffer)
//   slave  : the environment (imem model plus decode)
interface ifetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            imem_resp_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, imem_resp_ready,
    output out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_resp_ready,
    input  out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction prefetch unit.
// Owns the fetch PC and keeps up to MAX_OUTSTANDING pipelined imem requests in
// flight. Returned instructions are queued with their PCs in a DEPTH-entry
// FIFO that feeds decode. A redirect reloads the fetch PC, flushes the FIFO
// and marks every still-outstanding request as stale so that its response is
// discarded on arrival.
// Ports:
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   redirect_valid : load redirect_pc as fetch PC and flush the buffer
//   redirect_pc    : new fetch PC (bits [1:0] ignored)
//   bus            : ifetch_buffer_if.master (imem request/response, decode)
//   count          : FIFO occupancy
// Optional feature (macro IFB_BYPASS_EN): when the FIFO is empty and nothing
// is being dropped, a returning response is presented to decode in the same
// cycle; it is only written into the FIFO if decode does not take it.
// With the macro undefined all decode outputs come from registered state.
module ifetch_buffer #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  ifetch_buffer_if.master          bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // Wide enough for count + outstanding without overflow.
  localparam int CW = AW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic [OW-1:0]   drop;

  // In-flight PC queue: one tag per issued request, consumed in order.
  logic [XLEN-1:0] pc_q [MAX_OUTSTANDING];
  logic [QW-1:0]   pq_wr;
  logic [QW-1:0]   pq_rd;
  logic [XLEN-1:0] pc_tag;

  // Instruction FIFO.
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic req_fire;
  logic resp_fire;
  logic resp_live;
  logic fifo_valid;
  logic push;
  logic pop;
  logic credit_ok;
  logic bypass_take;

  // Low PC bits are defined to be ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  function automatic logic [QW-1:0] pq_next(input logic [QW-1:0] ptr);
    // The queue depth need not be a power of two, so wrap explicitly.
    return (ptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + QW'(1);
  endfunction

  assign pc_tag     = pc_q[pq_rd];
  assign fifo_valid = (count != '0);

  // Every live request owns a FIFO slot: count + live outstanding < DEPTH.
  assign credit_ok = (outstanding < OW'(MAX_OUTSTANDING)) &&
                     ((CW'(count) + CW'(outstanding) - CW'(drop)) < CW'(DEPTH));

  assign bus.imem_req_valid  = reset_n && !redirect_valid && credit_ok;
  assign bus.imem_req_addr   = fetch_pc;
  assign bus.imem_resp_ready = 1'b1;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_fire = bus.imem_resp_valid;
  // A response is live when no stale request is ahead of it and no redirect
  // is flushing this cycle.
  assign resp_live = resp_fire && (drop == '0) && !redirect_valid;

`ifdef IFB_BYPASS_EN
  assign bypass_take = reset_n && resp_live && !fifo_valid;
  assign bus.out_valid = fifo_valid || bypass_take;
  assign bus.out_inst  = fifo_valid  ? inst_mem[rd_ptr] :
                         bypass_take ? bus.imem_resp_data : '0;
  assign bus.out_pc    = fifo_valid  ? pc_mem[rd_ptr] :
                         bypass_take ? pc_tag : '0;
  assign push = resp_live && !(bypass_take && bus.out_ready);
`else
  assign bypass_take = 1'b0;
  assign bus.out_valid = fifo_valid;
  // NOTE: FIFO storage has no reset; the head is masked while empty so the
  // outputs read 0 after reset without paying for resettable storage.
  assign bus.out_inst  = fifo_valid ? inst_mem[rd_ptr] : '0;
  assign bus.out_pc    = fifo_valid ? pc_mem[rd_ptr]   : '0;
  assign push = resp_live;
`endif

  // A redirect flushes the FIFO, so a simultaneous pop is meaningless.
  assign pop = fifo_valid && bus.out_ready && !redirect_valid;

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no
    // latch is inferred; blocking assignments are correct in combinational code.
    outstanding_next = outstanding;
    case ({req_fire, resp_fire})
      2'b10:   outstanding_next = outstanding + OW'(1);
      2'b01:   outstanding_next = outstanding - OW'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding_next;

      // The tag queue keeps tracking requests across redirects, so dropped
      // responses still consume their own tags.
      if (req_fire)  pq_wr <= pq_next(pq_wr);
      if (resp_fire) pq_rd <= pq_next(pq_rd);

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // Everything still in flight after this edge is stale; a response
        // arriving this same cycle is already excluded from outstanding_next.
        drop     <= outstanding_next;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_fire && (drop != '0)) drop <= drop - OW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage: written only, never reset.
  always_ff @(posedge clk) begin
    if (req_fire) pc_q[pq_wr] <= fetch_pc;
    if (push) begin
      inst_mem[wr_ptr] <= bus.imem_resp_data;
      pc_mem[wr_ptr]   <= pc_tag;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed self-checking bench for ifetch_buffer
// (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0, default build without bypass).
// The imem model answers requests in order, at the earliest one cycle after
// acceptance, with data derived from the address.
module tb_ifetch_buffer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic [2:0]      count;

  ifetch_buffer_if #(.XLEN(XLEN)) bus ();

  ifetch_buffer #(
    .XLEN(XLEN), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic mem_en = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] issued_q[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_inst[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic drive_resp();
    if (mem_en && pend_q.size() != 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend_q[0]);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  endtask

  // One clock: capture handshakes before the edge, update the model after it.
  task automatic tick();
    logic rf, sf, pf;
    logic [31:0] a, ppc, pin;
    rf  = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_req_addr;
    sf  = bus.imem_resp_valid && bus.imem_resp_ready;
    pf  = bus.out_valid && bus.out_ready;
    ppc = bus.out_pc;
    pin = bus.out_inst;
    @(posedge clk);
    #1;
    if (sf && pend_q.size() != 0) void'(pend_q.pop_front());
    if (rf) begin pend_q.push_back(a); issued_q.push_back(a); end
    if (pf) begin popped_pc.push_back(ppc); popped_inst.push_back(pin); end
    drive_resp();
    #1;
  endtask

  task automatic clear_model();
    pend_q.delete(); issued_q.delete(); popped_pc.delete(); popped_inst.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; mem_en = 1'b0;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.out_ready = 1'b0; bus.imem_req_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL reset_first_req got valid=%b addr=%h exp valid=1 addr=0", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.out_ready = 1'b1; mem_en = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_before_resp got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== mem_word(32'h0)) begin
      failures++; $display("FAIL stream_first_out got valid=%b pc=%h inst=%h exp valid=1 pc=0 inst=%h", bus.out_valid, bus.out_pc, bus.out_inst, mem_word(32'h0));
    end
    repeat (8) tick();
    checks++; if (issued_q.size() != 10) begin failures++; $display("FAIL stream_issue_count got=%0d exp=10", issued_q.size()); end
    checks++; if (popped_pc.size() != 8) begin failures++; $display("FAIL stream_pop_count got=%0d exp=8", popped_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < issued_q.size()) begin
        checks++; if (issued_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, issued_q[i], 32'(4 * i)); end
      end
      if (i < popped_pc.size()) begin
        checks++; if (popped_pc[i] !== 32'(4 * i) || popped_inst[i] !== mem_word(32'(4 * i))) begin
          failures++; $display("FAIL stream_out[%0d] got pc=%h inst=%h exp pc=%h inst=%h", i, popped_pc[i], popped_inst[i], 32'(4 * i), mem_word(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0; mem_en = 1'b1;
    repeat (8) tick();
    checks++; if (issued_q.size() != 4) begin failures++; $display("FAIL bp_issue_count got=%0d exp=4", issued_q.size()); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", count); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
    bus.out_ready = 1'b1; #1;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h10) begin
      failures++; $display("FAIL bp_resume got valid=%b addr=%h exp valid=1 addr=00000010", bus.imem_req_valid, bus.imem_req_addr);
    end
    checks++; if (popped_pc.size() != 1 || count !== 3'd3) begin
      failures++; $display("FAIL bp_first_pop got pops=%0d count=%0d exp pops=1 count=3", popped_pc.size(), count);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b1; mem_en = 1'b0;
    tick(); tick();
    checks++; if (issued_q.size() != 2 || bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL redir_inflight got issued=%0d valid=%b exp issued=2 valid=0", issued_q.size(), bus.imem_req_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103; mem_en = 1'b1; #1;
    tick();
    redirect_valid = 1'b0; #1;
    checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=00000100", bus.imem_req_addr); end
    repeat (6) tick();
    checks++; if (issued_q.size() < 3 || issued_q[2] !== 32'h100) begin
      failures++; $display("FAIL redir_first_req got n=%0d exp third issued addr 00000100", issued_q.size());
    end
    checks++; if (popped_pc.size() == 0) begin
      failures++; $display("FAIL redir_no_output got pops=0 exp >0");
    end else if (popped_pc[0] !== 32'h100 || popped_inst[0] !== mem_word(32'h100)) begin
      failures++; $display("FAIL redir_first_out got pc=%h inst=%h exp pc=00000100 inst=%h", popped_pc[0], popped_inst[0], mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    bus.out_ready = 1'b0; mem_en = 1'b1;
    repeat (3) tick();
    mem_en = 1'b0;
    tick();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL coll_setup_count got=%0d exp=3", count); end
    mem_en = 1'b1; drive_resp();
    bus.out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.imem_resp_valid !== 1'b1) begin
      failures++; $display("FAIL coll_redirect_cycle got req_valid=%b resp_valid=%b exp 0 and 1", bus.imem_req_valid, bus.imem_resp_valid);
    end
    tick();
    redirect_valid = 1'b0; #1;
    checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL coll_flush got count=%0d valid=%b exp count=0 valid=0", count, bus.out_valid);
    end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
      failures++; $display("FAIL coll_restart got valid=%b addr=%h exp valid=1 addr=00000200", bus.imem_req_valid, bus.imem_req_addr);
    end
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_inst !== mem_word(32'h200)) begin
      failures++; $display("FAIL coll_first_out got valid=%b pc=%h inst=%h exp valid=1 pc=00000200 inst=%h", bus.out_valid, bus.out_pc, bus.out_inst, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_en = 1'b0; bus.out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    tick();
    redirect_valid = 1'b0; bus.imem_req_ready = 1'b0; #1;
    checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=fffffffc", bus.imem_req_addr); end
    tick(); tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_stall_hold got valid=%b addr=%h exp valid=1 addr=fffffffc", bus.imem_req_valid, bus.imem_req_addr);
    end
    bus.imem_req_ready = 1'b1; #1;
    tick();
    checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", bus.imem_req_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_ready = 1'b1; mem_en = 1'b1;
    repeat (5) tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL areset_precond got valid=%b exp=1", bus.out_valid); end
    #2; reset_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL areset_immediate got valid=%b req_valid=%b count=%0d exp 0 0 0", bus.out_valid, bus.imem_req_valid, count);
    end
    mem_en = 1'b0; bus.imem_resp_valid = 1'b0; clear_model();
    @(posedge clk); #1; reset_n = 1'b1; #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL areset_restart got valid=%b addr=%h exp valid=1 addr=0", bus.imem_req_valid, bus.imem_req_addr);
    end
    tick();
    checks++; if (issued_q.size() != 1 || issued_q[0] !== 32'h0) begin
      failures++; $display("FAIL areset_first_issue got n=%0d exp one request at 0", issued_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
